// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell walks the operands LSB first, one bit per clock.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN (adds the `sub` input).
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic bit_a, bit_b, fa_sum, fa_carry;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

  // Subtraction is folded into the operand latch: store ~op_b and seed the carry with 1.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load     = sub ? ~op_b : op_b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = op_b;
  assign carry_load = cin;
`endif

  // The single full-adder cell, shared by every bit position.
  always_comb begin
    bit_a    = a_q[cnt_q];
    bit_b    = b_q[cnt_q];
    fa_sum   = bit_a ^ bit_b ^ carry_q;
    fa_carry = (bit_a & bit_b) | (bit_b & carry_q) | (bit_a & carry_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = b_load;
          carry_d = carry_load;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[cnt_q] = fa_sum;
        carry_d      = fa_carry;
        cnt_d        = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          cout_d  = fa_carry;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl against an arithmetic reference model.
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, start, cin;
  logic [WIDTH-1:0] op_a, op_b;
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .op_a (op_a),
    .op_b (op_b),
    .cin  (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {cout, sum} is just the (WIDTH+1)-bit arithmetic result.
  function automatic logic [WIDTH:0] ref_result(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic c, input logic s);
    if (s)
      return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c);
  endfunction

  task automatic drive_sub(input logic s);
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`else
    if (s) $display("note: sub requested without subtract build");
`endif
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic c, input logic s);
    logic [WIDTH:0] exp;
    int n_busy;
    exp   = ref_result(a, b, c, s);
    start = 1'b1; op_a = a; op_b = b; cin = c; drive_sub(s);
    tick();
    start = 1'b0;
    op_a  = WIDTH'($urandom); op_b = WIDTH'($urandom); cin = 1'($urandom); drive_sub(1'($urandom));
    check_eq({tag, "_clr_sum"}, 32'(sum), 32'h0);
    check_eq({tag, "_clr_cout"}, 32'(cout), 32'h0);
    n_busy = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (busy && !done) n_busy++;
      tick();
    end
    check_eq({tag, "_busy_len"}, 32'(n_busy), 32'(WIDTH));
    check_eq({tag, "_done"}, 32'({busy, done}), 32'h1);
    check_eq({tag, "_sum"}, 32'(sum), 32'(exp[WIDTH-1:0]));
    check_eq({tag, "_cout"}, 32'(cout), 32'(exp[WIDTH]));
    tick();
    check_eq({tag, "_idle"}, 32'({busy, done}), 32'h0);
    check_eq({tag, "_hold"}, 32'({cout, sum}), 32'(exp));
    $display("op %s: a=0x%02h b=0x%02h cin=%0d sub=%0d -> sum=0x%02h cout=%0d", tag, a, b, c, s, sum, cout);
  endtask

  initial begin
    logic [WIDTH:0]   exp;
    logic [WIDTH-1:0] arr_a [30];
    logic [WIDTH-1:0] arr_b [30];
    logic             arr_c [30];
    int dones;

    rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0; drive_sub(1'b0);
    tick(); tick();
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_sum", 32'(sum), 32'h0);
    check_eq("rst_cout", 32'(cout), 32'h0);
    rst = 1'b0;

    run_op("basic", 8'h5A, 8'h33, 1'b0, 1'b0);
    run_op("wrap", 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("cin_wrap", 8'hFF, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++)
      run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);

    // start re-pulsed in RUN (cycle 3) and in DONE (cycle 9) must be ignored
    exp = ref_result(8'h12, 8'h34, 1'b1, 1'b0);
    start = 1'b1; op_a = 8'h12; op_b = 8'h34; cin = 1'b1;
    tick();
    dones = 0;
    for (int k = 1; k <= 14; k++) begin
      if (done) dones++;
      if (k == 9) check_eq("ign_sum_done", 32'({cout, sum}), 32'(exp));
      start = (k == 3 || k == 9);
      op_a = WIDTH'($urandom); op_b = WIDTH'($urandom); cin = 1'($urandom);
      tick();
    end
    start = 1'b0;
    check_eq("ign_done_count", 32'(dones), 32'h1);
    check_eq("ign_sum_hold", 32'({cout, sum}), 32'(exp));
    $display("ignore test: dones=%0d sum=0x%02h cout=%0d", dones, sum, cout);

    // reset during the 4th RUN cycle aborts with no done pulse
    start = 1'b1; op_a = 8'hAB; op_b = 8'hCD; cin = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check_eq("abort_busy_before", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_state", 32'({busy, done}), 32'h0);
    check_eq("abort_sum", 32'(sum), 32'h0);
    check_eq("abort_cout", 32'(cout), 32'h0);
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      if (done || busy) dones++;
      tick();
    end
    check_eq("abort_no_done", 32'(dones), 32'h0);
    $display("abort test: activity after reset=%0d", dones);

    // start held high: accepts every WIDTH+2 cycles, done at cycles 9, 19, 29
    for (int c = 0; c < 30; c++) begin
      arr_a[c] = WIDTH'($urandom); arr_b[c] = WIDTH'($urandom); arr_c[c] = 1'($urandom);
      start = 1'b1; op_a = arr_a[c]; op_b = arr_b[c]; cin = arr_c[c];
      tick();
      begin
        int k;
        k = c + 1;
        check_eq("b2b_busy", 32'(busy), 32'((k % 10) >= 1 && (k % 10) <= 8));
        check_eq("b2b_done", 32'(done), 32'((k % 10) == 9));
        if ((k % 10) == 9) begin
          exp = ref_result(arr_a[k-9], arr_b[k-9], arr_c[k-9], 1'b0);
          check_eq("b2b_result", 32'({cout, sum}), 32'(exp));
          $display("b2b done at cycle %0d: sum=0x%02h cout=%0d", k, sum, cout);
        end
      end
    end
    start = 1'b0;
    tick(); tick();

`ifdef SERIAL_ADDER_SUB_EN
    run_op("sub_borrow", 8'h05, 8'h07, 1'b1, 1'b1);
    run_op("sub_noborrow", 8'h07, 8'h05, 1'b0, 1'b1);
    run_op("sub_off", 8'h07, 8'h05, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op("sub_rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand bit count; legal range 2..32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin one addition.
REQ-005 The block SHALL have ports op_a and op_b, each input, WIDTH bits: the addend operands.
REQ-006 The block SHALL have port cin, input, 1 bit: the carry into bit 0.
REQ-007 The block SHALL have port busy, output, 1 bit: high while bits are being processed.
REQ-008 The block SHALL have port done, output, 1 bit: a one-cycle pulse when the result is valid.
REQ-009 The block SHALL have port sum, output, WIDTH bits: the result register.
REQ-010 The block SHALL have port cout, output, 1 bit: the carry out of bit WIDTH-1.

Function
REQ-011 The block SHALL evaluate the addition bit-serially, LSB first, through exactly one 1-bit full-adder cell (sum = a^b^c, carry = ab|bc|ac), reused every cycle.
REQ-012 The FSM SHALL have the states IDLE, RUN and DONE and no others; any unreachable encoding SHALL go to IDLE.
REQ-013 In IDLE, start=1 at a rising edge SHALL latch op_a, op_b and cin, clear the bit counter, and move to RUN; start=0 SHALL keep the FSM in IDLE.
REQ-014 In RUN, each edge SHALL process bit index = counter, write the cell's sum into sum[counter], store its carry in the carry register, and increment the counter.
REQ-015 After bit WIDTH-1 is processed, the FSM SHALL update cout at that same edge and move to DONE.
REQ-016 busy SHALL be high exactly in RUN, for WIDTH consecutive cycles.
REQ-017 done SHALL be high exactly in DONE, for one cycle, beginning WIDTH cycles after the start-accepting edge; the next edge SHALL return the FSM to IDLE.
REQ-018 start in RUN or DONE SHALL be ignored, with no queueing; op_a, op_b and cin changes after acceptance SHALL NOT affect the result.
REQ-019 sum and cout SHALL hold their last values from DONE until the next start is accepted.
REQ-020 Accepting a new start SHALL clear sum and cout to 0 at the accepting edge.
REQ-021 start held high continuously SHALL produce back-to-back operations with a period of WIDTH+2 cycles.
REQ-022 The result SHALL equal (op_a + op_b + cin) mod 2^WIDTH, and cout SHALL be the carry out of that sum.

Reset
REQ-023 On rst=1 at an edge, the FSM SHALL go to IDLE, and busy, done, cout, sum, the counter and the carry register SHALL all be 0.
REQ-024 rst SHALL take priority over start and over an operation in progress; an aborted operation SHALL produce no done pulse.
REQ-025 After rst deasserts, the first start SHALL be accepted at the first edge where rst=0 and start=1.

Configuration
REQ-026 When the macro SERIAL_ADDER_SUB_EN is defined, the block SHALL add an input port sub (1 bit), latched with the operands.
REQ-027 With the macro defined and sub=1, the cell SHALL use ~op_b bits and an initial carry of 1, ignoring cin, so that sum = op_a - op_b and cout = 1 when there is no borrow; with sub=0 the behaviour SHALL be as in REQ-022.
REQ-028 Without the macro, the sub port and its logic SHALL be absent, and the block SHALL only add.

Verification
REQ-029 The bench SHALL cover: WIDTH=8, op_a=0x5A, op_b=0x33, cin=0, start pulse -> busy for 8 cycles, then done for 1 cycle with sum=0x8D and cout=0.
REQ-030 The bench SHALL cover: op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00 and cout=1; then op_a=0xFF, op_b=0x00, cin=1 -> sum=0x00 and cout=1.
REQ-031 The bench SHALL cover: start re-pulsed during RUN and during DONE with different operands -> ignored, the first result is unchanged, and only one done pulse occurs.
REQ-032 The bench SHALL cover: rst asserted at the 4th RUN cycle -> next cycle busy=0, done=0, sum=0x00, cout=0, and no done pulse follows.
REQ-033 The bench SHALL cover: start held high for 30 cycles -> done pulses at cycles 9, 19 and 29 after the first acceptance, with correct results each time.
REQ-034 The bench SHALL cover, with SERIAL_ADDER_SUB_EN defined: sub=1, op_a=0x05, op_b=0x07 -> sum=0xFE and cout=0; then op_a=0x07, op_b=0x05 -> sum=0x02 and cout=1.
